// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-control bundle between the MIPS pipeline (master) and hazard_stall_ctrl (slave).
interface hazard_stall_ctrl_if;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 32;

  logic             IDEX_memread_ctrl;
  logic [REG_W-1:0] IDEX_reg_rt;
  logic [REG_W-1:0] IFID_reg_rs;
  logic [REG_W-1:0] IFID_reg_rt;
  logic             IFID_uses_rt;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_write_en;
  logic             IFID_write_en;
  logic             IDEX_bubble;
  logic             IFID_flush;
  logic             pipe_freeze;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] lu_stall_cnt;
  logic [CNT_W-1:0] mem_stall_cnt;

  modport master (
    output IDEX_memread_ctrl, IDEX_reg_rt, IFID_reg_rs, IFID_reg_rt, IFID_uses_rt,
           branch_taken, dmem_req, dmem_ready,
    input  pc_write_en, IFID_write_en, IDEX_bubble, IFID_flush, pipe_freeze,
           mem_timeout_err, lu_stall_cnt, mem_stall_cnt
  );

  modport slave (
    input  IDEX_memread_ctrl, IDEX_reg_rt, IFID_reg_rs, IFID_reg_rt, IFID_uses_rt,
           branch_taken, dmem_req, dmem_ready,
    output pc_write_en, IFID_write_en, IDEX_bubble, IFID_flush, pipe_freeze,
           mem_timeout_err, lu_stall_cnt, mem_stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall, memory-wait freeze and branch flush control with a timeout-guarded wait FSM.
// Optional stall counters are built when HAZARD_STALL_CNT_EN is defined; otherwise they read 0.
module hazard_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  hazard_stall_ctrl_if.slave hz
);
  localparam int unsigned WCNT_W = 8;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                lu, mw;
  logic                pc_we, ifid_we, bubble, flush, freeze, err;

  assign lu = hz.IDEX_memread_ctrl && (hz.IDEX_reg_rt != '0) &&
              ((hz.IDEX_reg_rt == hz.IFID_reg_rs) ||
               (hz.IFID_uses_rt && (hz.IDEX_reg_rt == hz.IFID_reg_rt)));
  assign mw = hz.dmem_req && !hz.dmem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next state and same-cycle stall/flush controls; freeze outranks load-use, which outranks flush.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pc_we   = 1'b1;
    ifid_we = 1'b1;
    bubble  = 1'b0;
    flush   = 1'b0;
    freeze  = 1'b0;
    err     = 1'b0;
    if (rst) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      bubble  = 1'b1;
      flush   = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mw) begin
            freeze  = 1'b1;
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            state_d = MEM_WAIT;
            wcnt_d  = WCNT_W'(1);
          end else if (lu) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            bubble  = 1'b1;
          end else if (hz.branch_taken) begin
            flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!hz.dmem_ready) begin
            freeze  = 1'b1;
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            wcnt_d  = wcnt_q + WCNT_W'(1);
            if (wcnt_q == WCNT_W'(MEM_TIMEOUT)) state_d = ERR;
          end else begin
            state_d = RUN;
            wcnt_d  = '0;
          end
        end
        ERR: begin
          freeze  = 1'b1;
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          err     = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign hz.pc_write_en     = pc_we;
  assign hz.IFID_write_en   = ifid_we;
  assign hz.IDEX_bubble     = bubble;
  assign hz.IFID_flush      = flush;
  assign hz.pipe_freeze     = freeze;
  assign hz.mem_timeout_err = err;

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d, mem_cnt_q, mem_cnt_d;

  // Saturating event counters.
  always_comb begin
    lu_cnt_d  = lu_cnt_q;
    mem_cnt_d = mem_cnt_q;
    if (bubble && (lu_cnt_q != '1))  lu_cnt_d  = lu_cnt_q + CNT_W'(1);
    if (freeze && (mem_cnt_q != '1)) mem_cnt_d = mem_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

  assign hz.lu_stall_cnt  = lu_cnt_q;
  assign hz.mem_stall_cnt = mem_cnt_q;
`else
  assign hz.lu_stall_cnt  = '0;
  assign hz.mem_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: single-cycle vector table plus multi-cycle wait/timeout/reset sequences.
module tb_hazard_stall_ctrl;
  localparam int unsigned TMO = 4;
`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  // Expected control word: {pc_write_en, IFID_write_en, IDEX_bubble, IFID_flush, pipe_freeze, mem_timeout_err}
  localparam logic [5:0] NRM = 6'b110000;
  localparam logic [5:0] LUS = 6'b001000;
  localparam logic [5:0] FLS = 6'b110100;
  localparam logic [5:0] FRZ = 6'b000010;
  localparam logic [5:0] ERO = 6'b000011;
  localparam logic [5:0] RST = 6'b001100;

  typedef struct packed {
    logic       rst;
    logic       memread;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       uses_rt;
    logic       br;
    logic       req;
    logic       rdy;
    logic [5:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t tbl[$];

  hazard_stall_ctrl_if hz();

  hazard_stall_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic mr, input logic [4:0] ert,
                              input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                              input logic b, input logic rq, input logic rd, input logic [5:0] e);
    vec_t v;
    v.rst = r; v.memread = mr; v.ex_rt = ert; v.id_rs = rs; v.id_rt = rt;
    v.uses_rt = ur; v.br = b; v.req = rq; v.rdy = rd; v.exp = e;
    return v;
  endfunction

  // Drive one cycle's inputs after the falling edge and check the same-cycle outputs.
  task automatic step(input vec_t v, input string name);
    logic [5:0] got;
    @(negedge clk);
    rst                  = v.rst;
    hz.IDEX_memread_ctrl = v.memread;
    hz.IDEX_reg_rt       = v.ex_rt;
    hz.IFID_reg_rs       = v.id_rs;
    hz.IFID_reg_rt       = v.id_rt;
    hz.IFID_uses_rt      = v.uses_rt;
    hz.branch_taken      = v.br;
    hz.dmem_req          = v.req;
    hz.dmem_ready        = v.rdy;
    #1;
    got = {hz.pc_write_en, hz.IFID_write_en, hz.IDEX_bubble, hz.IFID_flush,
           hz.pipe_freeze, hz.mem_timeout_err};
    checks++;
    if (got !== v.exp) begin
      errors++;
      $display("FAIL %s: ctrl got %b expected %b", name, got, v.exp);
    end
  endtask

  task automatic chk_cnt(input string name, input int exp_lu, input int exp_mem);
    logic [31:0] el, em;
    el = CNT_ON ? 32'(exp_lu) : 32'd0;
    em = CNT_ON ? 32'(exp_mem) : 32'd0;
    checks++;
    if (hz.lu_stall_cnt !== el) begin
      errors++;
      $display("FAIL %s lu_stall_cnt: got %0d expected %0d", name, hz.lu_stall_cnt, el);
    end
    checks++;
    if (hz.mem_stall_cnt !== em) begin
      errors++;
      $display("FAIL %s mem_stall_cnt: got %0d expected %0d", name, hz.mem_stall_cnt, em);
    end
  endtask

  task automatic idle(input logic r, input logic [5:0] e, input string name);
    step(mk(r, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, e), name);
  endtask

  task automatic wait_cyc(input logic rd, input logic [5:0] e, input string name);
    step(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, rd, e), name);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    hz.IDEX_memread_ctrl = 1'b0; hz.IDEX_reg_rt = '0; hz.IFID_reg_rs = '0;
    hz.IFID_reg_rt = '0; hz.IFID_uses_rt = 1'b0; hz.branch_taken = 1'b0;
    hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;

    //           rst mr ert    rs     rt    ur br rq rd exp
    tbl.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, RST));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NRM));
    tbl.push_back(mk(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, LUS));
    tbl.push_back(mk(0, 0, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, NRM));
    tbl.push_back(mk(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, NRM));
    tbl.push_back(mk(0, 1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 0, NRM));
    tbl.push_back(mk(0, 1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 0, LUS));
    tbl.push_back(mk(0, 1, 5'd7, 5'd3, 5'd4, 1, 0, 0, 0, NRM));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, FLS));
    tbl.push_back(mk(0, 1, 5'd9, 5'd9, 5'd0, 0, 1, 0, 0, LUS));
    tbl.push_back(mk(0, 0, 5'd9, 5'd9, 5'd0, 0, 1, 0, 0, FLS));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, NRM));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, NRM));
    tbl.push_back(mk(0, 1, 5'd31, 5'd30, 5'd31, 1, 0, 0, 0, LUS));

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));
    idle(0, NRM, "vec_tail");
    chk_cnt("vec_tail", 4, 0);

    // Memory wait: three not-ready cycles freeze, ready cycle releases.
    idle(1, RST, "mw_rst");
    wait_cyc(0, FRZ, "mw_c1");
    wait_cyc(0, FRZ, "mw_c2");
    wait_cyc(0, FRZ, "mw_c3");
    wait_cyc(1, NRM, "mw_ready");
    idle(0, NRM, "mw_after");
    chk_cnt("mw_after", 0, 3);

    // Timeout: one RUN freeze cycle, then TMO wait cycles before ERR.
    idle(1, RST, "to_rst");
    wait_cyc(0, FRZ, "to_run");
    for (int k = 1; k <= int'(TMO); k++) wait_cyc(0, FRZ, $sformatf("to_wait%0d", k));
    wait_cyc(0, ERO, "to_err");
    chk_cnt("to_err", 0, 5);
    wait_cyc(1, ERO, "to_sticky");
    idle(0, ERO, "to_sticky2");
    idle(1, RST, "to_clr_rst");
    idle(0, NRM, "to_cleared");
    chk_cnt("to_cleared", 0, 0);

    // Simultaneous freeze, load-use and branch.
    idle(1, RST, "sim_rst");
    step(mk(0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 0, FRZ), "sim_frz");
    step(mk(0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 1, NRM), "sim_release");
    step(mk(0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0, LUS), "sim_lu");
    step(mk(0, 0, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0, FLS), "sim_flush");
    idle(0, NRM, "sim_done");
    chk_cnt("sim_done", 1, 1);

    // Reset in the middle of a memory wait.
    idle(1, RST, "rmw_rst0");
    wait_cyc(0, FRZ, "rmw_c1");
    wait_cyc(0, FRZ, "rmw_c2");
    step(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, RST), "rmw_rst");
    idle(0, NRM, "rmw_run");
    chk_cnt("rmw_run", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline stall/flush controller for the 5-stage MIPS core; the producer side of the hazard path whose consumer is the EX-stage operand forwarding logic. It detects load-use hazards that forwarding cannot cover and inserts exactly one bubble. It freezes the whole pipeline while a multi-cycle data-memory access is outstanding and flushes IF/ID on a taken branch. A wait-state FSM with a timeout counter guards the memory handshake.

## Interface
- MEM_TIMEOUT, default 64: maximum MEM_WAIT cycles before the error state; legal range 2..255.

- clk  in  1  single pipeline clock
- rst  in  1  synchronous, active-high reset
- IDEX_memread_ctrl  in  1  instruction in EX is a load
- IDEX_reg_rt  in  5  load destination register in EX
- IFID_reg_rs  in  5  rs of instruction in ID
- IFID_reg_rt  in  5  rt of instruction in ID
- IFID_uses_rt  in  1  ID instruction reads rt as a source
- branch_taken  in  1  branch resolved taken in ID
- dmem_req  in  1  MEM stage has a data-memory access this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write_en  out  1  PC update enable
- IFID_write_en  out  1  IF/ID register enable
- IDEX_bubble  out  1  zero ID/EX control fields
- IFID_flush  out  1  clear IF/ID to NOP
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- mem_timeout_err  out  1  sticky timeout flag
- lu_stall_cnt  out  32  load-use bubble count
- mem_stall_cnt  out  32  memory freeze-cycle count

## Operation
- The load-use term lu is IDEX_memread_ctrl & (IDEX_reg_rt != 0) & ((IDEX_reg_rt == IFID_reg_rs) | (IFID_uses_rt & (IDEX_reg_rt == IFID_reg_rt))).
- The memory-wait term mw is dmem_req & !dmem_ready.
- FSM states: RUN, MEM_WAIT, ERR. The wait counter wcnt is 8 bits.
- RUN:
  - mw -> pipe_freeze=1, pc_write_en=0, IFID_write_en=0; next state MEM_WAIT; wcnt <= 1.
  - else lu -> pc_write_en=0, IFID_write_en=0, IDEX_bubble=1.
  - else branch_taken -> IFID_flush=1.
  - else all enables 1, all other control outputs 0.
- MEM_WAIT:
  - !dmem_ready -> freeze outputs as in RUN/mw; wcnt <= wcnt+1.
  - wcnt == MEM_TIMEOUT with dmem_ready still low -> next state ERR.
  - dmem_ready -> freeze released in the same cycle; next state RUN.
  - lu and branch_taken are evaluated only after returning to RUN.
- ERR: freeze outputs held and mem_timeout_err=1 until rst.
- Priority: freeze > load-use > flush. A branch coincident with a stall is not flushed; it is re-evaluated once the stall ends.
- A load-use stall naturally lasts one cycle, because the bubble clears IDEX_memread_ctrl.

## Timing
- All stall and flush outputs are combinational from the current state and inputs, valid in the same cycle. State, wcnt and the counters update on the rising clk edge.
- Reset behaviour while rst=1: pc_write_en=0, IFID_write_en=0, IDEX_bubble=1, IFID_flush=1, pipe_freeze=0, mem_timeout_err=0.
- On the first edge with rst=1: state=RUN, wcnt=0, both counters=0.
- rst asserted in MEM_WAIT or ERR returns to RUN on that edge; the error flag clears.
- A one-cycle access (dmem_ready asserted together with dmem_req) causes no freeze.

## Configuration
- HAZARD_STALL_CNT_EN defined:
  - lu_stall_cnt increments on every cycle with IDEX_bubble=1 outside reset.
  - mem_stall_cnt increments on every cycle with pipe_freeze=1.
  - Both counters saturate at 32'hFFFF_FFFF.
- HAZARD_STALL_CNT_EN undefined: both counter ports are present and tied to 0, and no counter flops are built.

## Test plan
- Load-use: IDEX_memread_ctrl=1, IDEX_reg_rt=5, IFID_reg_rs=5 -> one cycle with pc_write_en=0, IFID_write_en=0, IDEX_bubble=1. The next cycle, with IDEX_memread_ctrl=0, returns to normal operation; lu_stall_cnt=1 with the macro.
- Register $0 and an unused rt: IDEX_reg_rt=0, or a match on rt only with IFID_uses_rt=0 -> no stall.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles, then high -> pipe_freeze=1 for 3 cycles and 0 in the ready cycle; mem_stall_cnt=3.
- Timeout: MEM_TIMEOUT=4 with dmem_ready held low -> ERR after 4 wait cycles; mem_timeout_err=1 sticky; rst returns to RUN with the flag 0.
- Simultaneous hazards: mw and lu together -> freeze only. After release, lu gives one bubble; a branch_taken held through both is then flushed.
- Reset mid-wait: rst during MEM_WAIT -> next cycle is in RUN, the freeze is released, and the counters are 0.
